// File: rtl/ipf_pkg.sv
// Shared constants and types for the IPF LCU scheduler: FSM states, the
// parameter-word field layout and pixel-count constants.
package ipf_pkg;

   localparam int IMG_AW = 14;
   localparam int PRM_AW = 6;

   localparam int LCU_PIX = 256;
   localparam logic [IMG_AW-1:0] LAST_PIX = 14'h3FFF;

   // Field positions inside the 24-bit parameter word
   localparam int PRM_TYPE_LSB = 22;
   localparam int PRM_BAND_LSB = 17;
   localparam int PRM_WO_BIT   = 16;
   localparam int PRM_OFS_LSB  = 0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PRM0   = 3'd1,
      ST_PRM1   = 3'd2,
      ST_STREAM = 3'd3,
      ST_DRAIN  = 3'd4
   } state_e;

endpackage

// File: rtl/ipf_skid_buf.sv
// One-entry 8-bit skid register: holds the memory word that returns while the
// consumer is stalled and presents it ahead of any newer word.
module ipf_skid_buf (
   input  logic       clk,
   input  logic       reset,
   input  logic       inValid_i,
   input  logic [7:0] inData_i,
   input  logic       outReady_i,
   output logic       outValid_o,
   output logic [7:0] outData_o
);

   logic       full_q, full_d;
   logic [7:0] data_q, data_d;

   assign outValid_o = full_q | inValid_i;
   assign outData_o  = full_q ? data_q : inData_i;

   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (outReady_i) begin
         if (full_q) begin
            full_d = inValid_i;
            data_d = inData_i;
         end
      end else if (inValid_i && !full_q) begin
         full_d = 1'b1;
         data_d = inData_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/ipf_lcu_sched.sv
// Streams a 128x128 image in LCU-raster order into the IPF core, with per-LCU
// parameters, busy back-pressure and a bounded wait for the core's finish.
module ipf_lcu_sched
   import ipf_pkg::*;
#(
   parameter int LCU_LOG2  = 4,
   parameter int GRID_LOG2 = 3,
   parameter int DRAIN_TO  = 4096
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [IMG_AW-1:0] img_addr,
   input  logic [7:0]        img_data,
   output logic [PRM_AW-1:0] prm_addr,
   input  logic [23:0]       prm_data,
   output logic              in_en,
   output logic [7:0]        din,
   output logic [1:0]        ipf_type,
   output logic [4:0]        ipf_band_pos,
   output logic              ipf_wo_class,
   output logic [15:0]       ipf_offset,
   output logic [2:0]        lcu_x,
   output logic [2:0]        lcu_y,
   output logic [1:0]        lcu_size,
   input  logic              busy,
   input  logic              finish,
   output logic              done,
   output logic              err
);

   localparam int PIX_W  = 2 * (LCU_LOG2 + GRID_LOG2);
   localparam int LX_LSB = 2 * LCU_LOG2;
   localparam int LY_LSB = 2 * LCU_LOG2 + GRID_LOG2;
   localparam logic [LX_LSB-1:0] PREFETCH_PIX = LX_LSB'(LCU_PIX - 2);
   localparam logic [12:0]       DRAIN_LAST   = 13'(DRAIN_TO - 1);

   state_e              state_q, state_d;
   logic [PIX_W-1:0]    issueCnt_q, issueCnt_d;
   logic [PIX_W-1:0]    outCnt_q, outCnt_d;
   logic                issueVld_q, issueVld_d;
   logic                retVld_q, retVld_d;
   logic [PRM_AW-1:0]   prmAddr_q, prmAddr_d;
   logic [1:0]          prmPend_q, prmPend_d;
   logic [23:0]         shadow_q, shadow_d;
   logic [23:0]         prmOut_q, prmOut_d;
   logic [2:0]          lcuX_q, lcuX_d;
   logic [2:0]          lcuY_q, lcuY_d;
   logic                inEn_q, inEn_d;
   logic [7:0]          din_q, din_d;
   logic [12:0]         drainCnt_q, drainCnt_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   logic                skidValid;
   logic [7:0]          skidData;
   logic                streaming;
   logic                issueOk;
   logic                emit;

   assign streaming = (state_q == ST_STREAM);
   assign issueOk   = streaming && issueVld_q && !busy;
   assign emit      = streaming && !busy && skidValid;

   ipf_skid_buf u_skid (
      .clk        (clk),
      .reset      (reset),
      .inValid_i  (retVld_q),
      .inData_i   (img_data),
      .outReady_i (streaming && !busy),
      .outValid_o (skidValid),
      .outData_o  (skidData)
   );

   // A stalled issue is cancelled and the same address re-read, so at most one word needs skidding
   always_comb begin
      state_d    = state_q;
      issueCnt_d = issueCnt_q;
      outCnt_d   = outCnt_q;
      issueVld_d = issueVld_q;
      retVld_d   = 1'b0;
      prmAddr_d  = prmAddr_q;
      prmPend_d  = {prmPend_q[0], 1'b0};
      shadow_d   = prmPend_q[1] ? prm_data : shadow_q;
      prmOut_d   = prmOut_q;
      lcuX_d     = lcuX_q;
      lcuY_d     = lcuY_q;
      inEn_d     = 1'b0;
      din_d      = din_q;
      drainCnt_d = drainCnt_q;
      done_d     = 1'b0;
      err_d      = err_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               err_d     = 1'b0;
               prmAddr_d = '0;
               state_d   = ST_PRM0;
            end
         end
         ST_PRM0: state_d = ST_PRM1;
         ST_PRM1: begin
            shadow_d   = prm_data;
            issueCnt_d = '0;
            outCnt_d   = '0;
            issueVld_d = 1'b1;
            state_d    = ST_STREAM;
         end
         ST_STREAM: begin
            retVld_d = issueOk;
            if (issueOk) begin
               issueCnt_d = issueCnt_q + 1'b1;
               if (issueCnt_q == LAST_PIX) issueVld_d = 1'b0;
               if (issueCnt_q[LX_LSB-1:0] == PREFETCH_PIX) begin
                  prmAddr_d    = issueCnt_q[PIX_W-1:LX_LSB] + 1'b1;
                  prmPend_d[0] = 1'b1;
               end
            end
            // LCU parameters switch together with the first pixel of each LCU
            if (emit) begin
               inEn_d   = 1'b1;
               din_d    = skidData;
               outCnt_d = outCnt_q + 1'b1;
               if (outCnt_q[LX_LSB-1:0] == '0) begin
                  prmOut_d = shadow_q;
                  lcuX_d   = outCnt_q[LY_LSB-1:LX_LSB];
                  lcuY_d   = outCnt_q[PIX_W-1:LY_LSB];
               end
               if (outCnt_q == LAST_PIX) begin
                  drainCnt_d = '0;
                  state_d    = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (finish) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else if (drainCnt_q == DRAIN_LAST) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               drainCnt_d = drainCnt_q + 13'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         issueCnt_q <= '0;
         outCnt_q   <= '0;
         issueVld_q <= 1'b0;
         retVld_q   <= 1'b0;
         prmAddr_q  <= '0;
         prmPend_q  <= '0;
         shadow_q   <= '0;
         prmOut_q   <= '0;
         lcuX_q     <= '0;
         lcuY_q     <= '0;
         inEn_q     <= 1'b0;
         din_q      <= '0;
         drainCnt_q <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         issueCnt_q <= issueCnt_d;
         outCnt_q   <= outCnt_d;
         issueVld_q <= issueVld_d;
         retVld_q   <= retVld_d;
         prmAddr_q  <= prmAddr_d;
         prmPend_q  <= prmPend_d;
         shadow_q   <= shadow_d;
         prmOut_q   <= prmOut_d;
         lcuX_q     <= lcuX_d;
         lcuY_q     <= lcuY_d;
         inEn_q     <= inEn_d;
         din_q      <= din_d;
         drainCnt_q <= drainCnt_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign img_addr     = {issueCnt_q[PIX_W-1:LY_LSB], issueCnt_q[LX_LSB-1:LCU_LOG2],
                          issueCnt_q[LY_LSB-1:LX_LSB], issueCnt_q[LCU_LOG2-1:0]};
   assign prm_addr     = prmAddr_q;
   assign in_en        = inEn_q;
   assign din          = din_q;
   assign ipf_type     = prmOut_q[PRM_TYPE_LSB +: 2];
   assign ipf_band_pos = prmOut_q[PRM_BAND_LSB +: 5];
   assign ipf_wo_class = prmOut_q[PRM_WO_BIT];
   assign ipf_offset   = prmOut_q[PRM_OFS_LSB +: 16];
   assign lcu_x        = lcuX_q;
   assign lcu_y        = lcuY_q;
   assign lcu_size     = 2'd0;
   assign done         = done_q;
   assign err          = err_q;

endmodule

// File: tb/tb_ipf_lcu_sched.sv
// Self-checking bench for ipf_lcu_sched: memories, randomized busy/parameters,
// and a raster-order reference model derived from the image geometry.
module tb_ipf_lcu_sched;

   localparam int NPIX = 16384;

   logic        clk = 1'b0;
   logic        reset, start, busy, finish;
   logic [13:0] img_addr;
   logic [7:0]  img_data;
   logic [5:0]  prm_addr;
   logic [23:0] prm_data;
   logic        in_en;
   logic [7:0]  din;
   logic [1:0]  ipf_type;
   logic [4:0]  ipf_band_pos;
   logic        ipf_wo_class;
   logic [15:0] ipf_offset;
   logic [2:0]  lcu_x, lcu_y;
   logic [1:0]  lcu_size;
   logic        done, err;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [23:0] prmMem [64];
   logic [7:0]  obsDin [NPIX];
   logic [23:0] obsPrm [NPIX];
   logic [2:0]  obsLx  [NPIX];
   logic [2:0]  obsLy  [NPIX];
   int nPix, busyViol, gapViol, firstPixCyc, lastPixCyc;

   ipf_lcu_sched dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .img_addr     (img_addr),
      .img_data     (img_data),
      .prm_addr     (prm_addr),
      .prm_data     (prm_data),
      .in_en        (in_en),
      .din          (din),
      .ipf_type     (ipf_type),
      .ipf_band_pos (ipf_band_pos),
      .ipf_wo_class (ipf_wo_class),
      .ipf_offset   (ipf_offset),
      .lcu_x        (lcu_x),
      .lcu_y        (lcu_y),
      .lcu_size     (lcu_size),
      .busy         (busy),
      .finish       (finish),
      .done         (done),
      .err          (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Image contents depend on every address bit so misordered LCUs are visible
   function automatic logic [7:0] imgVal(input logic [13:0] a);
      return a[7:0] ^ {a[13:8], a[13:12]};
   endfunction

   always @(posedge clk) begin
      img_data <= imgVal(img_addr);
      prm_data <= prmMem[prm_addr];
   end

   // Raster-order address of the k-th streamed pixel
   function automatic logic [13:0] pixAddr(input int k);
      int ly, lx, row, col;
      ly  = k / 2048;
      lx  = (k / 256) % 8;
      row = (k / 16) % 16;
      col = k % 16;
      return 14'(ly * 2048 + row * 128 + lx * 16 + col);
   endfunction

   function automatic int pixelErrors(input int n, output int firstBad);
      int bad;
      int lcu;
      bad = 0;
      firstBad = -1;
      for (int k = 0; k < n; k++) begin
         lcu = k / 256;
         if (obsDin[k] !== imgVal(pixAddr(k)) || obsPrm[k] !== prmMem[lcu] ||
             obsLx[k] !== 3'(lcu % 8) || obsLy[k] !== 3'(lcu / 8)) begin
            if (firstBad < 0) firstBad = k;
            bad++;
         end
      end
      return bad;
   endfunction

   // mode 0: no back-pressure; mode 1: scripted stalls at pixels 100 and 254 plus random busy
   task automatic collect(input int target, input int mode);
      int holdLeft, budget, lcu;
      bit prevBusy;
      holdLeft = 0;
      budget = 60000;
      prevBusy = 1'b0;
      nPix = 0;
      busyViol = 0;
      gapViol = 0;
      while (nPix < target && budget > 0) begin
         @(negedge clk);
         budget--;
         start = 1'b0;
         finish = 1'b0;
         if (prevBusy && in_en) busyViol++;
         if (in_en) begin
            obsDin[nPix] = din;
            obsPrm[nPix] = {ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset};
            obsLx[nPix]  = lcu_x;
            obsLy[nPix]  = lcu_y;
            if (nPix == 0) firstPixCyc = cyc;
            lastPixCyc = cyc;
            nPix++;
            if (mode == 1 && nPix == 100) holdLeft = 5;
            if (mode == 1 && nPix == 254) holdLeft = 3;
            if (mode == 1 && nPix == 5000) start = 1'b1;
            if (mode == 1 && nPix == 6000) finish = 1'b1;
         end else if (nPix > 0) begin
            lcu = (nPix - 1) / 256;
            if ({ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset} !== prmMem[lcu] ||
                lcu_x !== 3'(lcu % 8) || lcu_y !== 3'(lcu / 8))
               gapViol++;
         end
         if (holdLeft > 0) begin
            busy = 1'b1;
            holdLeft--;
         end else begin
            busy = (mode == 1) && ($urandom_range(0, 7) == 0);
         end
         if (nPix >= target) busy = 1'b0;
         prevBusy = busy;
      end
      busy = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      start = 1'b0;
      busy = 1'b0;
      finish = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({img_addr, prm_addr} !== 20'd0) begin
         failures++;
         $display("[TB] FAIL reset_addr: got img=%0h prm=%0h expected 0", img_addr, prm_addr);
      end
      checks++;
      if ({in_en, din} !== 9'd0) begin
         failures++;
         $display("[TB] FAIL reset_pixel: got in_en=%0b din=%0h expected 0", in_en, din);
      end
      checks++;
      if ({ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset} !== 24'd0) begin
         failures++;
         $display("[TB] FAIL reset_params: got %0h expected 0", {ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset});
      end
      checks++;
      if ({lcu_x, lcu_y, lcu_size, done, err} !== 10'd0) begin
         failures++;
         $display("[TB] FAIL reset_status: got %0h expected 0", {lcu_x, lcu_y, lcu_size, done, err});
      end
      reset = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (in_en !== 1'b0) begin
         failures++;
         $display("[TB] FAIL idle_no_stream: got in_en=%0b expected 0", in_en);
      end
   endtask

   task automatic test_no_stall();
      int bad, firstBad;
      for (int i = 0; i < 64; i++) prmMem[i] = 24'($urandom);
      prmMem[0] = 24'h400001;
      prmMem[1] = 24'h800000;
      @(negedge clk);
      start = 1'b1;
      collect(NPIX, 0);
      checks++;
      if (nPix !== NPIX) begin
         failures++;
         $display("[TB] FAIL nostall_count: got %0d pixels expected %0d", nPix, NPIX);
      end
      bad = pixelErrors(nPix, firstBad);
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("[TB] FAIL nostall_pixels: got %0d bad pixels (first %0d) expected 0", bad, firstBad);
      end
      checks++;
      if (lastPixCyc - firstPixCyc !== NPIX - 1) begin
         failures++;
         $display("[TB] FAIL nostall_gaps: got span %0d expected %0d", lastPixCyc - firstPixCyc, NPIX - 1);
      end
      repeat ($urandom_range(1, 10)) @(negedge clk);
      checks++;
      if ({done, err} !== 2'b00) begin
         failures++;
         $display("[TB] FAIL drain_quiet: got done=%0b err=%0b expected 0 0", done, err);
      end
      finish = 1'b1;
      @(negedge clk);
      finish = 1'b0;
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("[TB] FAIL done_pulse: got %0b expected 1", done);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL done_one_cycle: got %0b expected 0", done);
      end
   endtask

   task automatic test_param_switch();
      checks++;
      if (obsPrm[255][23:22] !== 2'd1 || obsPrm[256][23:22] !== 2'd2) begin
         failures++;
         $display("[TB] FAIL type_switch: got %0d->%0d expected 1->2", obsPrm[255][23:22], obsPrm[256][23:22]);
      end
      checks++;
      if (obsLx[255] !== 3'd0 || obsLx[256] !== 3'd1) begin
         failures++;
         $display("[TB] FAIL lcux_switch: got %0d->%0d expected 0->1", obsLx[255], obsLx[256]);
      end
   endtask

   task automatic test_stall_timeout();
      int bad, firstBad, waited;
      bit sawDone, sawErr;
      for (int i = 0; i < 64; i++) prmMem[i] = 24'($urandom);
      @(negedge clk);
      start = 1'b1;
      collect(NPIX, 1);
      checks++;
      if (nPix !== NPIX) begin
         failures++;
         $display("[TB] FAIL stall_count: got %0d pixels expected %0d", nPix, NPIX);
      end
      bad = pixelErrors(nPix, firstBad);
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("[TB] FAIL stall_pixels: got %0d bad pixels (first %0d) expected 0", bad, firstBad);
      end
      checks++;
      if (busyViol !== 0) begin
         failures++;
         $display("[TB] FAIL stall_in_en: got %0d pixels after busy expected 0", busyViol);
      end
      checks++;
      if (gapViol !== 0) begin
         failures++;
         $display("[TB] FAIL stall_param_hold: got %0d unstable gap cycles expected 0", gapViol);
      end
      waited = 0;
      sawDone = 1'b0;
      sawErr = 1'b0;
      while (!sawErr && waited < 6000) begin
         @(negedge clk);
         waited++;
         if (done) sawDone = 1'b1;
         if (err) sawErr = 1'b1;
      end
      checks++;
      if (sawErr !== 1'b1 || waited !== 4096) begin
         failures++;
         $display("[TB] FAIL timeout_err: got err=%0b after %0d cycles expected 1 after 4096", sawErr, waited);
      end
      checks++;
      if (sawDone !== 1'b0) begin
         failures++;
         $display("[TB] FAIL timeout_no_done: got done seen=%0b expected 0", sawDone);
      end
      repeat (3) @(negedge clk);
      finish = 1'b1;
      @(negedge clk);
      finish = 1'b0;
      checks++;
      if ({done, err, in_en} !== 3'b010) begin
         failures++;
         $display("[TB] FAIL idle_after_timeout: got done=%0b err=%0b in_en=%0b expected 0 1 0", done, err, in_en);
      end
   endtask

   task automatic test_mid_reset();
      int bad, firstBad;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL start_clears_err: got %0b expected 0", err);
      end
      collect(3000, 0);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({in_en, din, img_addr, prm_addr, ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset,
           lcu_x, lcu_y, lcu_size, done, err} !== 63'd0) begin
         failures++;
         $display("[TB] FAIL midreset_zero: got in_en=%0b din=%0h img=%0h lcu=%0d,%0d expected all 0",
                  in_en, din, img_addr, lcu_x, lcu_y);
      end
      reset = 1'b1;
      @(negedge clk);
      start = 1'b1;
      collect(300, 1);
      checks++;
      if (nPix !== 300) begin
         failures++;
         $display("[TB] FAIL replay_count: got %0d pixels expected 300", nPix);
      end
      bad = pixelErrors(nPix, firstBad);
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("[TB] FAIL replay_pixels: got %0d bad pixels (first %0d) expected 0", bad, firstBad);
      end
      checks++;
      if (busyViol !== 0 || gapViol !== 0) begin
         failures++;
         $display("[TB] FAIL replay_stall: got busyViol=%0d gapViol=%0d expected 0 0", busyViol, gapViol);
      end
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      busy = 1'b0;
      finish = 1'b0;
      for (int i = 0; i < 64; i++) prmMem[i] = '0;
      $display("[TB] starting ipf_lcu_sched bench");
      test_reset();
      test_no_stall();
      test_param_switch();
      test_stall_timeout();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
